cmp_event_log: RTL

Event-capture and readback block on the `fdbk_core` `cmp_event` output.
- Per channel, it records the cycle timestamp of the most recent event, a saturating event count and a sticky "seen" flag.
- All records are readable over the local bus; this block is the read-side responder, the complement of the existing write-only decode.
- It lets software and benches check SEL limiter and comparator activity (e.g. "last event well before now") without probing internals.

---
 rtl/cmp_event_log_pkg.sv | 14 +
 rtl/cmp_event_log_chan.sv | 42 ++++
 rtl/cmp_event_log.sv | 115 +++++++++++
 3 files changed

// File: rtl/cmp_event_log_pkg.sv
// Address map and control-bit layout shared by the event log and its channels.
package cmp_event_log_pkg;

    localparam logic [7:0] ADDR_NOW  = 8'h00;
    localparam logic [7:0] ADDR_SEEN = 8'h01;
    localparam logic [7:0] ADDR_CTRL = 8'h02;
    localparam logic [7:0] BASE_TS   = 8'h10;
    localparam logic [7:0] BASE_CNT  = 8'h20;

    localparam int CTRL_FREEZE = 0;
    localparam int CTRL_CLEAR  = 1;
    localparam int WRAP_BIT    = 31;

endpackage

// File: rtl/cmp_event_log_chan.sv
// One channel record: last-event timestamp, saturating count and sticky seen flag.
// Clear beats everything; a same-cycle event beats clear-on-read so no event is lost.
module cmp_event_chan #(
    parameter int TW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          evt,
    input  logic [TW-1:0] now,
    input  logic          freeze,
    input  logic          clear,
    input  logic          seen_clr,
    output logic [TW-1:0] ts,
    output logic [CW-1:0] cnt,
    output logic          seen
);
    import cmp_event_log_pkg::*;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts   <= '0;
            cnt  <= '0;
            seen <= 1'b0;
        end else if (clear) begin
            ts   <= '0;
            cnt  <= '0;
            seen <= 1'b0;
        end else begin
            if (evt && !freeze) begin
                ts <= now;
                if (cnt != '1)
                    cnt <= cnt + CW'(1);
            end
            if (evt)
                seen <= 1'b1;
            else if (seen_clr)
                seen <= 1'b0;
        end
    end

endmodule

// File: rtl/cmp_event_log.sv
// Per-channel cmp_event capture with a two-stage local-bus read pipeline.
// Reads of 0x01 snapshot seen/wrap at the request edge so the returned word is pre-clear.
module cmp_event_log #(
    parameter int NCH = 12,
    parameter int TW  = 32,
    parameter int CW  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] cmp_event,
    input  logic [7:0]     lb_addr,
    input  logic           lb_write,
    input  logic [31:0]    lb_data,
    input  logic           lb_read,
    output logic [31:0]    lb_dout,
    output logic           lb_rvalid
);
    import cmp_event_log_pkg::*;

    logic [TW-1:0]           now;
    logic                    wrap;
    logic                    freeze;
    logic                    ctrl_wr;
    logic                    clear;
    logic                    seen_rd;
    logic [NCH-1:0]          seen;
    logic [NCH-1:0][TW-1:0]  ts;
    logic [NCH-1:0][CW-1:0]  cnt;
    logic [31:0]             seen_word;
    logic                    rd_vld;
    logic [7:0]              rd_addr;
    logic [31:0]             rd_seen;
    logic [31:0]             rd_word;
    logic                    unused_data;

    assign ctrl_wr     = lb_write && (lb_addr == ADDR_CTRL);
    assign clear       = ctrl_wr && lb_data[CTRL_CLEAR];
    assign seen_rd     = lb_read && (lb_addr == ADDR_SEEN);
    assign unused_data = ^lb_data[31:2];

    for (genvar n = 0; n < NCH; n++) begin : g_chan
        cmp_event_chan #(.TW(TW), .CW(CW)) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .evt      (cmp_event[n]),
            .now      (now),
            .freeze   (freeze),
            .clear    (clear),
            .seen_clr (seen_rd),
            .ts       (ts[n]),
            .cnt      (cnt[n]),
            .seen     (seen[n])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now    <= '0;
            wrap   <= 1'b0;
            freeze <= 1'b0;
        end else begin
            now <= now + TW'(1);
            if (clear)
                wrap <= 1'b0;
            else if (&now)
                wrap <= 1'b1;
            else if (seen_rd)
                wrap <= 1'b0;
            if (ctrl_wr)
                freeze <= lb_data[CTRL_FREEZE];
        end
    end

    always_comb begin
        seen_word           = '0;
        seen_word[NCH-1:0]  = seen;
        seen_word[WRAP_BIT] = wrap;
    end

    always_comb begin
        rd_word = '0;
        if (rd_addr == ADDR_NOW)
            rd_word = 32'(now);
        if (rd_addr == ADDR_SEEN)
            rd_word = rd_seen;
        if (rd_addr == ADDR_CTRL)
            rd_word[CTRL_FREEZE] = freeze;
        for (int n = 0; n < NCH; n++) begin
            if (rd_addr == BASE_TS + 8'(n))
                rd_word = 32'(ts[n]);
            if (rd_addr == BASE_CNT + 8'(n))
                rd_word = 32'(cnt[n]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld    <= 1'b0;
            rd_addr   <= '0;
            rd_seen   <= '0;
            lb_rvalid <= 1'b0;
            lb_dout   <= '0;
        end else begin
            rd_vld    <= lb_read;
            lb_rvalid <= rd_vld;
            if (lb_read) begin
                rd_addr <= lb_addr;
                rd_seen <= seen_word;
            end
            if (rd_vld)
                lb_dout <= rd_word;
        end
    end

endmodule
